// File: rtl/ex_stage_md_if.sv
// Bundle of ID/EX inputs and EX/MEM outputs for the ex_stage_md execute stage.
// The master side belongs to the pipeline (ID/EX, hazard unit); the slave side belongs to the stage.
interface ex_stage_md_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
);
  logic              valid_i;
  logic              flush_i;
  logic              stall_i;
  logic [1:0]        fwd_a_i;
  logic [1:0]        fwd_b_i;
  logic [XLEN-1:0]   rd1_i;
  logic [XLEN-1:0]   rd2_i;
  logic [XLEN-1:0]   result_w_i;
  logic [XLEN-1:0]   alu_result_m_i;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   pc_i;
  logic              alu_src_i;
  logic [2:0]        alu_ctrl_i;
  logic              md_i;
  logic [2:0]        funct3_i;
  logic [4:0]        rd_i;
  logic [CTRL_W-1:0] ctrl_i;

  logic              busy_o;
  logic              valid_o;
  logic              eq_o;
  logic [XLEN-1:0]   alu_out_o;
  logic [XLEN-1:0]   pc_plus_imm_o;
  logic [XLEN-1:0]   write_data_o;
  logic [4:0]        rd_o;
  logic [CTRL_W-1:0] ctrl_o;

  modport master (
    output valid_i, flush_i, stall_i, fwd_a_i, fwd_b_i, rd1_i, rd2_i, result_w_i,
           alu_result_m_i, imm_i, pc_i, alu_src_i, alu_ctrl_i, md_i, funct3_i, rd_i, ctrl_i,
    input  busy_o, valid_o, eq_o, alu_out_o, pc_plus_imm_o, write_data_o, rd_o, ctrl_o
  );

  modport slave (
    input  valid_i, flush_i, stall_i, fwd_a_i, fwd_b_i, rd1_i, rd2_i, result_w_i,
           alu_result_m_i, imm_i, pc_i, alu_src_i, alu_ctrl_i, md_i, funct3_i, rd_i, ctrl_i,
    output busy_o, valid_o, eq_o, alu_out_o, pc_plus_imm_o, write_data_o, rd_o, ctrl_o
  );
endinterface

// File: rtl/ex_stage_md.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative RV32M unit, EX/MEM register.
// Define EX_FAST_MUL_EN to run MUL/MULH/MULHSU/MULHU on a single-cycle combinational multiplier.
module ex_stage_md #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  ex_stage_md_if.slave bus
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic              valid;
    logic              eq;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   pc_plus_imm;
    logic [XLEN-1:0]   write_data;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } exmem_t;

  state_e            state_q, state_d;
  logic              busy, accept, md_iter, single_cycle;
  logic [XLEN-1:0]   op_a, op_b, alu_b, alu_res, ex_res, md_res;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;

  md_op_e            f_q;
  logic              sign_q, a_neg_q, div0_q, is_div_q;
  logic [XLEN-1:0]   mcand_q, dividend_q;
  logic [2*XLEN-1:0] acc_q, mul_next, div_next, mul_full;
  logic [CW-1:0]     cnt_q;
  logic [4:0]        rd_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic              mul_carry;
  logic [XLEN-1:0]   mul_sum;
  logic [XLEN:0]     r_shift;
  logic              div_ge;

  exmem_t            exmem_q, exmem_d;

  // Operand forwarding: 11 falls back to the register-file value.
  always_comb begin
    case (bus.fwd_a_i)
      2'b01:   op_a = bus.result_w_i;
      2'b10:   op_a = bus.alu_result_m_i;
      default: op_a = bus.rd1_i;
    endcase
    case (bus.fwd_b_i)
      2'b01:   op_b = bus.result_w_i;
      2'b10:   op_b = bus.alu_result_m_i;
      default: op_b = bus.rd2_i;
    endcase
    alu_b = bus.alu_src_i ? bus.imm_i : op_b;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl_i)
      ALU_ADD: alu_res = op_a + alu_b;
      ALU_SUB: alu_res = op_a - alu_b;
      ALU_AND: alu_res = op_a & alu_b;
      ALU_OR:  alu_res = op_a | alu_b;
      ALU_XOR: alu_res = op_a ^ alu_b;
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
      ALU_SLL: alu_res = op_a << alu_b[SHW-1:0];
      ALU_SRL: alu_res = op_a >> alu_b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  // Operand signedness and magnitudes for the RV32M op presented in ID/EX.
  always_comb begin
    a_signed = (bus.funct3_i == MD_MULH) || (bus.funct3_i == MD_MULHSU) ||
               (bus.funct3_i == MD_DIV)  || (bus.funct3_i == MD_REM);
    b_signed = (bus.funct3_i == MD_MULH) || (bus.funct3_i == MD_DIV) ||
               (bus.funct3_i == MD_REM);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_abs    = a_neg ? -op_a : op_a;
    b_abs    = b_neg ? -op_b : op_b;
  end

`ifdef EX_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  always_comb begin
    fast_prod = {{XLEN{a_neg}}, op_a} * {{XLEN{b_neg}}, op_b};
    md_iter   = bus.md_i & bus.funct3_i[2];
    ex_res    = alu_res;
    if (bus.md_i)
      ex_res = (bus.funct3_i == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  always_comb begin
    md_iter = bus.md_i;
    ex_res  = alu_res;
  end
`endif

  assign accept       = (state_q == S_IDLE) & bus.valid_i & md_iter & ~bus.flush_i;
  assign single_cycle = bus.valid_i & ~md_iter;

  // One iteration: shift-add multiply or restoring divide sharing the same 2*XLEN register.
  always_comb begin
    {mul_carry, mul_sum} = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, acc_q[0] ? mcand_q : '0};
    mul_next = {mul_carry, mul_sum, acc_q[XLEN-1:1]};
    r_shift  = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = r_shift >= {1'b0, mcand_q};
    div_next = {div_ge ? XLEN'(r_shift - {1'b0, mcand_q}) : r_shift[XLEN-1:0],
                acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    mul_full = sign_q ? -acc_q : acc_q;
    md_res   = '0;
    case (f_q)
      MD_MUL:                        md_res = mul_full[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  md_res = mul_full[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:
        md_res = div0_q ? '1 : (sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
      MD_REM, MD_REMU:
        md_res = div0_q ? dividend_q
                        : (a_neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]);
      default: md_res = '0;
    endcase
  end

  // Next state and busy; busy drops in DONE once MEM can take the result.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_RUN;
        busy    = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
        if (bus.flush_i)           state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.flush_i)      state_d = S_IDLE;
        else if (bus.stall_i) busy    = 1'b1;
        else                  state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: the MD working registers are reset explicitly so a mid-operation reset leaves no stale operands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_q        <= MD_MUL;
      sign_q     <= 1'b0;
      a_neg_q    <= 1'b0;
      div0_q     <= 1'b0;
      is_div_q   <= 1'b0;
      mcand_q    <= '0;
      dividend_q <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      rd_q       <= '0;
      ctrl_q     <= '0;
    end else if (accept) begin
      f_q        <= md_op_e'(bus.funct3_i);
      sign_q     <= a_neg ^ b_neg;
      a_neg_q    <= a_neg;
      div0_q     <= (op_b == '0);
      is_div_q   <= bus.funct3_i[2];
      mcand_q    <= bus.funct3_i[2] ? b_abs : a_abs;
      dividend_q <= op_a;
      acc_q      <= {{XLEN{1'b0}}, bus.funct3_i[2] ? a_abs : b_abs};
      cnt_q      <= '0;
      rd_q       <= bus.rd_i;
      ctrl_q     <= bus.ctrl_i;
    end else if (state_q == S_RUN) begin
      acc_q <= is_div_q ? div_next : mul_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // EX/MEM next value; all-zero is a bubble.
  always_comb begin
    exmem_d = '0;
    if (bus.flush_i) begin
      exmem_d = '0;
    end else if (state_q == S_DONE) begin
      exmem_d.valid   = 1'b1;
      exmem_d.alu_out = md_res;
      exmem_d.rd      = rd_q;
      exmem_d.ctrl    = ctrl_q;
    end else if (!busy && single_cycle) begin
      exmem_d.valid       = 1'b1;
      exmem_d.eq          = (op_a == op_b);
      exmem_d.alu_out     = ex_res;
      exmem_d.pc_plus_imm = bus.pc_i + bus.imm_i;
      exmem_d.write_data  = op_b;
      exmem_d.rd          = bus.rd_i;
      exmem_d.ctrl        = bus.ctrl_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           exmem_q <= '0;
    else if (!bus.stall_i) exmem_q <= exmem_d;
  end

  assign bus.busy_o        = busy;
  assign bus.valid_o       = exmem_q.valid;
  assign bus.eq_o          = exmem_q.eq;
  assign bus.alu_out_o     = exmem_q.alu_out;
  assign bus.pc_plus_imm_o = exmem_q.pc_plus_imm;
  assign bus.write_data_o  = exmem_q.write_data;
  assign bus.rd_o          = exmem_q.rd;
  assign bus.ctrl_o        = exmem_q.ctrl;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU ops, forwarding, RV32M results and latency, flush, stall, reset.
module tb_ex_stage_md;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_md_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

  ex_stage_md #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.valid_i = 0; bus.flush_i = 0; bus.stall_i = 0;
    bus.fwd_a_i = 0; bus.fwd_b_i = 0;
    bus.rd1_i = 0; bus.rd2_i = 0; bus.result_w_i = 0; bus.alu_result_m_i = 0;
    bus.imm_i = 0; bus.pc_i = 0; bus.alu_src_i = 0; bus.alu_ctrl_i = 0;
    bus.md_i = 0; bus.funct3_i = 0; bus.rd_i = 0; bus.ctrl_i = 0;
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    bus.valid_i = 1; bus.md_i = 0; bus.fwd_a_i = 0; bus.fwd_b_i = 0; bus.alu_src_i = 0;
    bus.alu_ctrl_i = op; bus.rd1_i = a; bus.rd2_i = b;
    tick;
    check(tag, bus.alu_out_o, exp);
    check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd1);
  endtask

  task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int busy_cnt;
    int exp_busy;
    busy_cnt = 0;
    exp_busy = 33;
`ifdef EX_FAST_MUL_EN
    if (!f3[2]) exp_busy = 0;
`endif
    bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = f3; bus.rd1_i = a; bus.rd2_i = b;
    bus.fwd_a_i = 0; bus.fwd_b_i = 0; bus.alu_src_i = 0; bus.rd_i = 5'd7;
    bus.stall_i = 0; bus.flush_i = 0;
    #1;
    while (bus.busy_o && busy_cnt < 200) begin
      busy_cnt++;
      tick;
      bus.valid_i = 0;
      #1;
    end
    check({tag, " busy cycles"}, busy_cnt, exp_busy);
    tick;
    bus.valid_i = 0; bus.md_i = 0;
    check(tag, bus.alu_out_o, exp);
    check({tag, " valid"}, {31'd0, bus.valid_o}, 32'd1);
    check({tag, " rd"}, {27'd0, bus.rd_o}, 32'd7);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    check("reset valid", {31'd0, bus.valid_o}, 32'd0);
    check("reset busy", {31'd0, bus.busy_o}, 32'd0);
    check("reset alu_out", bus.alu_out_o, 32'd0);
    check("reset eq", {31'd0, bus.eq_o}, 32'd0);
    rst_n = 1;
    tick;

    // ADD with immediate operand
    bus.valid_i = 1; bus.rd1_i = 5; bus.imm_i = 7; bus.alu_src_i = 1; bus.alu_ctrl_i = 3'd0;
    bus.pc_i = 32'h100; bus.rd_i = 5'd3; bus.ctrl_i = 8'h5A;
    tick;
    check("add imm", bus.alu_out_o, 32'd12);
    check("add valid", {31'd0, bus.valid_o}, 32'd1);
    check("add busy", {31'd0, bus.busy_o}, 32'd0);
    check("add pc+imm", bus.pc_plus_imm_o, 32'h107);
    check("add rd", {27'd0, bus.rd_o}, 32'd3);
    check("add ctrl", {24'd0, bus.ctrl_o}, 32'h5A);

    // Forwarding from MEM on A, then from WB on B
    bus.alu_src_i = 0; bus.imm_i = 0; bus.fwd_a_i = 2'b10; bus.alu_result_m_i = 32'h10;
    bus.rd1_i = 32'h55; bus.rd2_i = 1; bus.alu_ctrl_i = 3'd1;
    tick;
    check("sub fwd_m", bus.alu_out_o, 32'hF);
    check("sub store data", bus.write_data_o, 32'd1);
    check("sub eq", {31'd0, bus.eq_o}, 32'd0);
    bus.fwd_b_i = 2'b01; bus.result_w_i = 32'h10; bus.alu_ctrl_i = 3'd0;
    tick;
    check("fwd eq", {31'd0, bus.eq_o}, 32'd1);
    check("fwd add", bus.alu_out_o, 32'h20);

    alu_op(3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    alu_op(3'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or");
    alu_op(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    alu_op(3'd5, 32'hFFFFFFFF, 32'd1, 32'd1, "slt neg");
    alu_op(3'd5, 32'd1, 32'hFFFFFFFF, 32'd0, "slt pos");
    alu_op(3'd6, 32'd1, 32'd33, 32'd2, "sll wrap amt");
    alu_op(3'd7, 32'h80000000, 32'd36, 32'h08000000, "srl wrap amt");
    alu_op(3'd1, 32'd0, 32'd1, 32'hFFFFFFFF, "sub wrap");
    alu_op(3'd0, 32'hFFFFFFFF, 32'd1, 32'd0, "add wrap");

    // Stall holds the EX/MEM register
    bus.stall_i = 1;
    bus.rd1_i = 32'd40; bus.rd2_i = 32'd2;
    tick;
    check("stall hold", bus.alu_out_o, 32'd0);
    bus.stall_i = 0;
    tick;
    check("stall release", bus.alu_out_o, 32'd42);
    bus.valid_i = 0;
    tick;

    run_md(3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, "mul");
    run_md(3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulh");
    run_md(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu");
    run_md(3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, "mulhu");
    run_md(3'd0, 32'd123, 32'd456, 32'd56088, "mul small");
    run_md(3'd4, 32'd7, 32'd0, 32'hFFFFFFFF, "div by 0");
    run_md(3'd6, 32'd7, 32'd0, 32'd7, "rem by 0");
    run_md(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div ovf");
    run_md(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem ovf");
    run_md(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div -7/2");
    run_md(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem -7/2");
    run_md(3'd5, 32'd100, 32'd7, 32'd14, "divu");
    run_md(3'd7, 32'd100, 32'd7, 32'd2, "remu");
    run_md(3'd7, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, "remu by 0");

    // Flush in the middle of a DIVU
    bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = 3'd5; bus.rd1_i = 100; bus.rd2_i = 7;
    #1;
    check("flush accept busy", {31'd0, bus.busy_o}, 32'd1);
    tick;
    bus.valid_i = 0; bus.md_i = 0;
    repeat (9) tick;
    bus.flush_i = 1;
    #1;
    check("flush same-cycle busy", {31'd0, bus.busy_o}, 32'd1);
    tick;
    bus.flush_i = 0;
    #1;
    check("flush busy drop", {31'd0, bus.busy_o}, 32'd0);
    check("flush bubble", {31'd0, bus.valid_o}, 32'd0);
    repeat (3) tick;
    check("flush no result", {31'd0, bus.valid_o}, 32'd0);
    alu_op(3'd0, 32'd1, 32'd2, 32'd3, "add after flush");
    bus.valid_i = 0;
    tick;

    // Stall held over the DONE cycle
    bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = 3'd5; bus.rd1_i = 100; bus.rd2_i = 7;
    tick;
    bus.valid_i = 0; bus.md_i = 0; bus.stall_i = 1;
    repeat (32) tick;
    for (int i = 0; i < 5; i++) begin
      check("stall done busy", {31'd0, bus.busy_o}, 32'd1);
      check("stall done valid", {31'd0, bus.valid_o}, 32'd0);
      tick;
    end
    bus.stall_i = 0;
    #1;
    check("stall done release busy", {31'd0, bus.busy_o}, 32'd0);
    tick;
    check("stall divu result", bus.alu_out_o, 32'd14);
    check("stall divu valid", {31'd0, bus.valid_o}, 32'd1);
    tick;
    check("stall divu one pulse", {31'd0, bus.valid_o}, 32'd0);

    // Reset in the middle of a divide
    bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = 3'd4; bus.rd1_i = 50; bus.rd2_i = 3;
    tick;
    bus.valid_i = 0; bus.md_i = 0;
    repeat (5) tick;
    rst_n = 0;
    #1;
    check("midreset busy", {31'd0, bus.busy_o}, 32'd0);
    check("midreset valid", {31'd0, bus.valid_o}, 32'd0);
    check("midreset alu_out", bus.alu_out_o, 32'd0);
    rst_n = 1;
    tick;
    run_md(3'd4, 32'd50, 32'd3, 32'd16, "div after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
